// File: rtl/xt_bus_pkg.sv
// ----------------------------------------------------------------------------
// xt_bus_pkg
// Shared definitions for the hb load/store master:
//   - RISC-V funct3 encodings for loads/stores
//   - hb_write_width encoding (byte/half/word)
//   - lsu_state_t FSM state enum
//   - helpers classifying a request as illegal or misaligned
// ----------------------------------------------------------------------------
package xt_bus_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] WW_BYTE = 2'b00;
  localparam logic [1:0] WW_HALF = 2'b01;
  localparam logic [1:0] WW_WORD = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_WR_ACTIVE,
    ST_RESP
  } lsu_state_t;

  // Reserved encodings, and the unsigned variants which have no store form.
  function automatic logic f3_illegal(input logic is_store, input logic [2:0] f3);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) ||
           (is_store && f3[2]);
  endfunction

  // Size comes from funct3[1:0], so H and HU share the halfword rule.
  function automatic logic addr_misaligned(input logic [2:0] f3, input logic [1:0] a);
    return ((f3[1:0] == WW_HALF) && a[0]) ||
           ((f3[1:0] == WW_WORD) && (a != 2'b00));
  endfunction

endpackage

// File: rtl/hb_load_extend.sv
// ----------------------------------------------------------------------------
// hb_load_extend
// Combinational load-data extension. The slave returns data right-justified;
// this masks the unused upper bytes and sign/zero extends by funct3.
// Ports:
//   i_funct3 [2:0]  latched load funct3
//   i_rdata  [31:0] right-justified slave read data
//   o_data   [31:0] extended result for the core
// ----------------------------------------------------------------------------
module hb_load_extend
  import xt_bus_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_data
);

  always_comb begin
    o_data = i_rdata;
    case (i_funct3)
      F3_B:    o_data = {{24{i_rdata[7]}}, i_rdata[7:0]};
      F3_H:    o_data = {{16{i_rdata[15]}}, i_rdata[15:0]};
      F3_BU:   o_data = {24'h0, i_rdata[7:0]};
      F3_HU:   o_data = {16'h0, i_rdata[15:0]};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/hb_lsu_master.sv
// ----------------------------------------------------------------------------
// hb_lsu_master
// Turns single core load/store requests into hb bus read/write accesses.
// Ports:
//   hb_clk, rst_n                 clock, async active-low reset
//   req_valid/req_ready           request handshake (ready only in IDLE)
//   req_is_store, req_funct3      access kind and size
//   req_addr, req_wdata           byte address, LSB-aligned store data
//   hb_raddr, hb_waddr, hb_wdata  latched address/data toward the slave
//   hb_write_width                00 byte, 01 half, 10 word
//   hb_ren, hb_wen                read strobe (one cycle) / write strobe (held)
//   hb_rdata, hb_read_finish,
//   hb_write_finish               slave read data and completion flags
//   rsp_valid, rsp_rdata,
//   rsp_misaligned, rsp_err       one-cycle response to the core
// Misaligned or illegal requests respond the cycle after acceptance without
// touching the bus. Bus waits are bounded by TIMEOUT_CYCLES.
// ----------------------------------------------------------------------------
module hb_lsu_master
  import xt_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        hb_clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] hb_raddr,
  output logic [31:0] hb_waddr,
  output logic [31:0] hb_wdata,
  output logic [1:0]  hb_write_width,
  output logic        hb_ren,
  output logic        hb_wen,
  input  logic [31:0] hb_rdata,
  input  logic        hb_read_finish,
  input  logic        hb_write_finish,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_misaligned,
  output logic        rsp_err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW:0] TIMEOUT_LIM = (CW + 1)'(TIMEOUT_CYCLES);

  lsu_state_t  r_state;
  lsu_state_t  w_state_next;
  logic        r_is_store;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_err;
  logic        r_rsp_mis;
  logic [CW-1:0] r_cnt;

  logic        w_accept;
  logic        w_req_illegal;
  logic        w_req_mis;
  logic [CW:0] w_cnt_inc;
  logic        w_expired;
  logic [31:0] w_ext_data;

  assign w_accept      = req_valid && (r_state == ST_IDLE);
  assign w_req_illegal = f3_illegal(req_is_store, req_funct3);
  assign w_req_mis     = addr_misaligned(req_funct3, req_addr[1:0]);

  // r_cnt holds completed wait cycles; the current wait cycle is the
  // (r_cnt+1)th, and the access is abandoned when that reaches the limit.
  assign w_cnt_inc = {1'b0, r_cnt} + {{CW{1'b0}}, 1'b1};
  assign w_expired = (w_cnt_inc >= TIMEOUT_LIM);

  hb_load_extend u_load_extend (
    .i_funct3 (r_funct3),
    .i_rdata  (hb_rdata),
    .o_data   (w_ext_data)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_req_illegal || w_req_mis) w_state_next = ST_RESP;
          else if (req_is_store)          w_state_next = ST_WR_ACTIVE;
          else                            w_state_next = ST_RD_ISSUE;
        end
      end
      ST_RD_ISSUE:  w_state_next = ST_RD_WAIT;
      // A finish in the expiry cycle still completes the access cleanly.
      ST_RD_WAIT:   if (hb_read_finish || w_expired) w_state_next = ST_RESP;
      ST_WR_ACTIVE: if (hb_write_finish || w_expired) w_state_next = ST_RESP;
      ST_RESP:      w_state_next = ST_IDLE;
      default:      w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge hb_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_is_store  <= 1'b0;
      r_funct3    <= 3'b000;
      r_addr      <= 32'h0;
      r_wdata     <= 32'h0;
      r_rsp_rdata <= 32'h0;
      r_rsp_err   <= 1'b0;
      r_rsp_mis   <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_is_store  <= req_is_store;
            r_funct3    <= req_funct3;
            r_addr      <= req_addr;
            r_wdata     <= req_wdata;
            r_rsp_rdata <= 32'h0;
            r_rsp_err   <= w_req_illegal;
            r_rsp_mis   <= !w_req_illegal && w_req_mis;
            r_cnt       <= '0;
          end
        end
        ST_RD_ISSUE: r_cnt <= '0;
        ST_RD_WAIT: begin
          if (hb_read_finish) begin
            r_rsp_rdata <= w_ext_data;
          end else begin
            r_cnt <= w_cnt_inc[CW-1:0];
            if (w_expired) r_rsp_err <= 1'b1;
          end
        end
        ST_WR_ACTIVE: begin
          if (!hb_write_finish) begin
            r_cnt <= w_cnt_inc[CW-1:0];
            if (w_expired) r_rsp_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready      = (r_state == ST_IDLE);
  assign hb_ren         = (r_state == ST_RD_ISSUE);
  assign hb_wen         = (r_state == ST_WR_ACTIVE);
  assign hb_raddr       = r_addr;
  assign hb_waddr       = r_addr;
  assign hb_wdata       = r_wdata;
  assign hb_write_width = r_funct3[1:0];

  // Response fields read as zero outside the RESP cycle.
  assign rsp_valid      = (r_state == ST_RESP);
  assign rsp_rdata      = rsp_valid ? r_rsp_rdata : 32'h0;
  assign rsp_err        = rsp_valid && r_rsp_err;
  assign rsp_misaligned = rsp_valid && r_rsp_mis;

endmodule

// File: tb/tb_hb_lsu_master.sv
module tb_hb_lsu_master;

  logic        hb_clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] hb_raddr, hb_waddr, hb_wdata;
  logic [1:0]  hb_write_width;
  logic        hb_ren, hb_wen;
  logic [31:0] hb_rdata;
  logic        hb_read_finish, hb_write_finish;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_misaligned, rsp_err;

  always #5 hb_clk = ~hb_clk;

  hb_lsu_master #(.TIMEOUT_CYCLES(8)) dut (
    .hb_clk          (hb_clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_is_store    (req_is_store),
    .req_funct3      (req_funct3),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .hb_raddr        (hb_raddr),
    .hb_waddr        (hb_waddr),
    .hb_wdata        (hb_wdata),
    .hb_write_width  (hb_write_width),
    .hb_ren          (hb_ren),
    .hb_wen          (hb_wen),
    .hb_rdata        (hb_rdata),
    .hb_read_finish  (hb_read_finish),
    .hb_write_finish (hb_write_finish),
    .rsp_valid       (rsp_valid),
    .rsp_rdata       (rsp_rdata),
    .rsp_misaligned  (rsp_misaligned),
    .rsp_err         (rsp_err)
  );

  typedef struct {
    string       nm;
    logic [31:0] rdata;
    logic        err;
    logic        mis;
    int          ren_n;
    int          wen_n;
    int          lat;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  width;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_mis = 0;
  int   cyc = 0;

  // slave configuration for the current transaction
  int          rd_delay = 0;
  int          wr_delay = 0;
  logic [31:0] slave_rdata = 32'h0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input string nm, input logic [31:0] rdata,
                              input logic err, input logic mis, input int ren_n,
                              input int wen_n, input int lat, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [1:0] width);
    exp_t e;
    e.nm = nm; e.rdata = rdata; e.err = err; e.mis = mis; e.ren_n = ren_n;
    e.wen_n = wen_n; e.lat = lat; e.addr = addr; e.wdata = wdata; e.width = width;
    return e;
  endfunction

  initial forever begin
    @(posedge hb_clk);
    cyc++;
  end

  // Slave model: read finish the cycle after ren (plus rd_delay), write finish
  // in the first wen cycle (plus wr_delay). rdata is only driven with finish.
  initial begin
    bit ren_seen, rd_armed, wr_busy;
    int rd_left, wr_left;
    rd_armed = 0; wr_busy = 0; rd_left = 0; wr_left = 0;
    hb_read_finish = 0; hb_write_finish = 0; hb_rdata = 32'h0;
    forever begin
      @(negedge hb_clk);
      ren_seen = hb_ren;
      @(posedge hb_clk);
      #1;
      if (!rst_n) begin
        rd_armed = 0; wr_busy = 0;
        hb_read_finish = 0; hb_write_finish = 0; hb_rdata = 32'h0;
        continue;
      end
      if (ren_seen) begin
        rd_armed = 1;
        rd_left  = rd_delay;
      end
      hb_read_finish = 0;
      hb_rdata = 32'h0;
      if (rd_armed) begin
        if (rd_left == 0) begin
          hb_read_finish = 1;
          hb_rdata = slave_rdata;
          rd_armed = 0;
        end else begin
          rd_left--;
        end
      end
      hb_write_finish = 0;
      if (hb_wen) begin
        if (!wr_busy) begin
          wr_busy = 1;
          wr_left = wr_delay;
        end
        if (wr_left == 0) hb_write_finish = 1;
        else wr_left--;
      end else begin
        wr_busy = 0;
      end
    end
  end

  // Monitor: tracks each accepted request and checks it when rsp_valid appears.
  initial begin
    bit          trk, seen;
    int          acc, ren_n, wen_n;
    logic [31:0] m_raddr, m_waddr, m_wdata;
    logic [1:0]  m_width;
    exp_t        e;
    trk = 0; seen = 0; acc = 0; ren_n = 0; wen_n = 0;
    m_raddr = '0; m_waddr = '0; m_wdata = '0; m_width = '0;
    forever begin
      @(negedge hb_clk);
      if (!rst_n) begin
        trk = 0;
        continue;
      end
      if (trk) begin
        ren_n = ren_n + int'(hb_ren);
        wen_n = wen_n + int'(hb_wen);
        if ((hb_ren || hb_wen) && !seen) begin
          seen = 1;
          m_raddr = hb_raddr;
          m_waddr = hb_waddr;
        end
        if (hb_wen) begin
          m_wdata = hb_wdata;
          m_width = hb_write_width;
        end
      end
      if (rsp_valid) begin
        if (!trk || sb.size() == 0) begin
          chk("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk({e.nm, "_rdata"}, rsp_rdata, e.rdata);
          chk({e.nm, "_err"}, 32'(rsp_err), 32'(e.err));
          chk({e.nm, "_mis"}, 32'(rsp_misaligned), 32'(e.mis));
          chk({e.nm, "_ren_cycles"}, ren_n, e.ren_n);
          chk({e.nm, "_wen_cycles"}, wen_n, e.wen_n);
          chk({e.nm, "_latency"}, cyc - acc, e.lat);
          chk({e.nm, "_ready_in_resp"}, 32'(req_ready), 32'd0);
          if (e.ren_n + e.wen_n > 0) begin
            chk({e.nm, "_raddr"}, m_raddr, e.addr);
            chk({e.nm, "_waddr"}, m_waddr, e.addr);
          end
          if (e.wen_n > 0) begin
            chk({e.nm, "_wdata"}, m_wdata, e.wdata);
            chk({e.nm, "_width"}, 32'(m_width), 32'(e.width));
          end
          $display("txn %-12s rdata=%08h err=%0d mis=%0d ren=%0d wen=%0d lat=%0d",
                   e.nm, rsp_rdata, rsp_err, rsp_misaligned, ren_n, wen_n, cyc - acc);
        end
        trk = 0;
      end
      if (req_valid && req_ready) begin
        trk = 1; seen = 0; acc = cyc; ren_n = 0; wen_n = 0;
        m_raddr = '0; m_waddr = '0; m_wdata = '0; m_width = '0;
      end
    end
  end

  task automatic issue(input exp_t e, input bit st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] srd, input int rdly, input int wdly,
                       input bit push);
    slave_rdata = srd;
    rd_delay = rdly;
    wr_delay = wdly;
    if (push) sb.push_back(e);
    @(posedge hb_clk);
    #1;
    req_valid = 1; req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge hb_clk);
    #1;
    req_valid = 0;
    if (push) begin
      for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge hb_clk);
      chk({e.nm, "_done"}, sb.size(), 0);
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got 0x%08h expected 0x%08h", 32'd1, 32'd0);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 0; req_valid = 0; req_is_store = 0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(posedge hb_clk);
    #1;
    chk("rst_ren", 32'(hb_ren), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    #3 rst_n = 1;
    @(negedge hb_clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_wen", 32'(hb_wen), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_raddr", hb_raddr, 32'h0);
    chk("rst_width", 32'(hb_write_width), 32'd0);

    //       name                 rdata         err mis ren wen lat addr   wdata        width
    issue(mk("lb_neg",     32'hFFFF_FF80, 0, 0, 1, 0, 3, 32'h3, 32'h0, 2'b00),
          0, 3'b000, 32'h3, 32'h0, 32'h0000_0080, 0, 0, 1);
    issue(mk("lhu_8001",   32'h0000_8001, 0, 0, 1, 0, 3, 32'h2, 32'h0, 2'b00),
          0, 3'b101, 32'h2, 32'h0, 32'h1234_8001, 0, 0, 1);
    issue(mk("lw_misal",   32'h0, 0, 1, 0, 0, 1, 32'h0, 32'h0, 2'b00),
          0, 3'b010, 32'h6, 32'h0, 32'h0, 0, 0, 1);
    issue(mk("sh_wait3",   32'h0, 0, 0, 0, 4, 5, 32'h2, 32'h0000_ABCD, 2'b01),
          1, 3'b001, 32'h2, 32'h0000_ABCD, 32'h0, 0, 3, 1);
    issue(mk("lh_neg",     32'hFFFF_8001, 0, 0, 1, 0, 3, 32'h0, 32'h0, 2'b00),
          0, 3'b001, 32'h0, 32'h0, 32'h0000_8001, 0, 0, 1);
    issue(mk("lbu_mask",   32'h0000_009C, 0, 0, 1, 0, 3, 32'h1, 32'h0, 2'b00),
          0, 3'b100, 32'h1, 32'h0, 32'hFFFF_FF9C, 0, 0, 1);
    issue(mk("lw_pass",    32'hDEAD_BEEF, 0, 0, 1, 0, 3, 32'h4, 32'h0, 2'b00),
          0, 3'b010, 32'h4, 32'h0, 32'hDEAD_BEEF, 0, 0, 1);
    issue(mk("sw_fast",    32'h0, 0, 0, 0, 1, 2, 32'h8, 32'h1122_3344, 2'b10),
          1, 3'b010, 32'h8, 32'h1122_3344, 32'h0, 0, 0, 1);
    issue(mk("sb_fast",    32'h0, 0, 0, 0, 1, 2, 32'h5, 32'h0000_0055, 2'b00),
          1, 3'b000, 32'h5, 32'h0000_0055, 32'h0, 0, 0, 1);
    issue(mk("st_f3_100",  32'h0, 1, 0, 0, 0, 1, 32'h0, 32'h0, 2'b00),
          1, 3'b100, 32'h0, 32'h1, 32'h0, 0, 0, 1);
    issue(mk("ld_f3_011",  32'h0, 1, 0, 0, 0, 1, 32'h0, 32'h0, 2'b00),
          0, 3'b011, 32'h0, 32'h0, 32'h0, 0, 0, 1);
    issue(mk("lw_timeout", 32'h0, 1, 0, 1, 0, 10, 32'h10, 32'h0, 2'b00),
          0, 3'b010, 32'h10, 32'h0, 32'h5555_5555, 1000, 0, 1);
    issue(mk("lw_fin8",    32'hCAFE_F00D, 0, 0, 1, 0, 10, 32'h14, 32'h0, 2'b00),
          0, 3'b010, 32'h14, 32'h0, 32'hCAFE_F00D, 7, 0, 1);
    issue(mk("sw_timeout", 32'h0, 1, 0, 0, 8, 9, 32'h18, 32'h0BAD_0BAD, 2'b10),
          1, 3'b010, 32'h18, 32'h0BAD_0BAD, 32'h0, 0, 1000, 1);
    issue(mk("sh_misal",   32'h0, 0, 1, 0, 0, 1, 32'h0, 32'h0, 2'b00),
          1, 3'b001, 32'h1, 32'h1234, 32'h0, 0, 0, 1);

    // Reset during RD_WAIT: no response may follow.
    issue(mk("lw_reset", 32'h0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 2'b00),
          0, 3'b010, 32'hC, 32'h0, 32'h7777_7777, 1000, 0, 0);
    @(posedge hb_clk);
    #3;
    rst_n = 0;
    #1;
    chk("midrst_ren", 32'(hb_ren), 32'd0);
    chk("midrst_wen", 32'(hb_wen), 32'd0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_ready", 32'(req_ready), 32'd1);
    chk("midrst_raddr", hb_raddr, 32'h0);
    repeat (2) @(posedge hb_clk);
    #3 rst_n = 1;
    repeat (6) @(posedge hb_clk);

    issue(mk("lh_after",   32'h0000_7FFF, 0, 0, 1, 0, 3, 32'h2, 32'h0, 2'b00),
          0, 3'b001, 32'h2, 32'h0, 32'h0000_7FFF, 0, 0, 1);

    repeat (5) @(posedge hb_clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
